// File: rtl/dbg_inst_encoder_pkg.sv
// Shared types and MIPS32 encoders for the debug instruction injector.
// The encoders are kept here so decode can reuse them for round-trip checks.
package dbg_inst_encoder_pkg;

  typedef enum logic [1:0] {
    CMD_WR_REG = 2'd0,
    CMD_RD_MEM = 2'd1,
    CMD_WR_MEM = 2'd2,
    CMD_JUMP   = 2'd3
  } dbg_cmd_e;

  typedef struct packed {
    dbg_cmd_e    op;
    logic [4:0]  gpr;
    logic [31:0] addr;
    logic [31:0] data;
  } dbg_cmd_s;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [31:0] INST_NOP  = 32'h0000_0000;
  localparam int          SEQ_MAX   = 5;

  function automatic logic [31:0] enc_lui(input logic [4:0] rt, input logic [15:0] imm);
    return {OP_LUI, 5'd0, rt, imm};
  endfunction

  function automatic logic [31:0] enc_ori(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
    return {OP_ORI, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_mem(input logic [5:0] opc, input logic [4:0] base,
                                          input logic [4:0] rt);
    return {opc, base, rt, 16'h0000};
  endfunction

  function automatic logic [31:0] enc_jr(input logic [4:0] rs);
    return {OP_SPECIAL, rs, 15'h0000, FUNCT_JR};
  endfunction

endpackage

// File: rtl/dbg_inst_encoder.sv
// Debug instruction injector: turns a debug command into a short MIPS32 word
// sequence and streams it out over a valid/ready interface.
module dbg_inst_encoder
  import dbg_inst_encoder_pkg::*;
#(
  parameter logic [4:0] SCRATCH_A = 5'd26,
  parameter logic [4:0] SCRATCH_B = 5'd27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_reg,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic        abort,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic        busy,
  output logic        done
);

  typedef enum logic {ST_IDLE, ST_EMIT} state_e;

  state_e                    state_q;
  logic [SEQ_MAX-1:0][31:0]  words_q;
  logic [2:0]                len_q;
  logic [2:0]                idx_q;
  logic [31:0]               inst_q;
  logic                      inst_valid_q;

  dbg_cmd_s                  cmd;
  logic [SEQ_MAX-1:0][31:0]  seq_w_d;
  logic [2:0]                seq_n_d;
  logic                      accept;
  logic                      last;
  logic [2:0]                idx_d;

  assign cmd = '{op: dbg_cmd_e'(cmd_op), gpr: cmd_reg, addr: cmd_addr, data: cmd_data};

  // Build the whole sequence from the live command; it is captured on the handshake.
  // A zero upper half drops the LUI and makes the ORI source $0.
  always_comb begin
    seq_w_d = '0;
    seq_n_d = 3'd0;
    if (cmd.op != CMD_WR_REG) begin
      if (cmd.addr[31:16] != 16'h0) begin
        seq_w_d[seq_n_d] = enc_lui(SCRATCH_A, cmd.addr[31:16]);
        seq_n_d          = seq_n_d + 3'd1;
        seq_w_d[seq_n_d] = enc_ori(SCRATCH_A, SCRATCH_A, cmd.addr[15:0]);
      end else begin
        seq_w_d[seq_n_d] = enc_ori(5'd0, SCRATCH_A, cmd.addr[15:0]);
      end
      seq_n_d = seq_n_d + 3'd1;
    end
    case (cmd.op)
      CMD_WR_REG: begin
        if (cmd.data[31:16] != 16'h0) begin
          seq_w_d[seq_n_d] = enc_lui(cmd.gpr, cmd.data[31:16]);
          seq_n_d          = seq_n_d + 3'd1;
          seq_w_d[seq_n_d] = enc_ori(cmd.gpr, cmd.gpr, cmd.data[15:0]);
        end else begin
          seq_w_d[seq_n_d] = enc_ori(5'd0, cmd.gpr, cmd.data[15:0]);
        end
        seq_n_d = seq_n_d + 3'd1;
      end
      CMD_RD_MEM: begin
        seq_w_d[seq_n_d] = enc_mem(OP_LW, SCRATCH_A, cmd.gpr);
        seq_n_d          = seq_n_d + 3'd1;
      end
      CMD_WR_MEM: begin
        if (cmd.data[31:16] != 16'h0) begin
          seq_w_d[seq_n_d] = enc_lui(SCRATCH_B, cmd.data[31:16]);
          seq_n_d          = seq_n_d + 3'd1;
          seq_w_d[seq_n_d] = enc_ori(SCRATCH_B, SCRATCH_B, cmd.data[15:0]);
        end else begin
          seq_w_d[seq_n_d] = enc_ori(5'd0, SCRATCH_B, cmd.data[15:0]);
        end
        seq_n_d          = seq_n_d + 3'd1;
        seq_w_d[seq_n_d] = enc_mem(OP_SW, SCRATCH_A, SCRATCH_B);
        seq_n_d          = seq_n_d + 3'd1;
      end
      default: begin
        seq_w_d[seq_n_d] = enc_jr(SCRATCH_A);
        seq_n_d          = seq_n_d + 3'd1;
        seq_w_d[seq_n_d] = INST_NOP;
        seq_n_d          = seq_n_d + 3'd1;
      end
    endcase
  end

  assign accept = inst_valid_q & inst_ready;
  assign last   = (idx_q == (len_q - 3'd1));
  assign idx_d  = idx_q + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      words_q      <= '0;
      len_q        <= 3'd0;
      idx_q        <= 3'd0;
      inst_q       <= 32'h0;
      inst_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid && !abort) begin
            words_q      <= seq_w_d;
            len_q        <= seq_n_d;
            idx_q        <= 3'd0;
            inst_q       <= seq_w_d[0];
            inst_valid_q <= 1'b1;
            state_q      <= ST_EMIT;
          end
        end
        default: begin
          if (abort || (accept && last)) begin
            state_q      <= ST_IDLE;
            idx_q        <= 3'd0;
            inst_q       <= 32'h0;
            inst_valid_q <= 1'b0;
          end else if (accept) begin
            idx_q  <= idx_d;
            inst_q <= words_q[idx_d];
          end
        end
      endcase
    end
  end

  // abort wins over a same-cycle command handshake
  assign cmd_ready  = (state_q == ST_IDLE) && !abort;
  assign busy       = (state_q == ST_EMIT);
  assign done       = (state_q == ST_EMIT) && accept && last && !abort;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;

endmodule

// File: tb/tb_dbg_inst_encoder.sv
// Self-checking bench for dbg_inst_encoder: directed table, corner sequences, random commands.
module tb_dbg_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [4:0]  cmd_reg = 5'd0;
  logic [31:0] cmd_addr = 32'h0;
  logic [31:0] cmd_data = 32'h0;
  logic        abort = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic        busy;
  logic        done;

  dbg_inst_encoder dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_reg(cmd_reg), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .abort(abort),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  r;
    logic [31:0] addr;
    logic [31:0] data;
    int          len;
    logic [31:0] w[5];
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic set_vec(input int k, input logic [1:0] op, input logic [4:0] r,
                         input logic [31:0] a, input logic [31:0] d, input int len,
                         input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                         input logic [31:0] w3, input logic [31:0] w4);
    vecs[k].op = op; vecs[k].r = r; vecs[k].addr = a; vecs[k].data = d; vecs[k].len = len;
    vecs[k].w[0] = w0; vecs[k].w[1] = w1; vecs[k].w[2] = w2; vecs[k].w[3] = w3; vecs[k].w[4] = w4;
  endtask

  // Reference model: instruction fields assembled arithmetically from the encoding rules.
  function automatic logic [31:0] mk(input int opc, input int rs, input int rt, input int imm);
    int unsigned v;
    v = (opc * 32'h0400_0000) + (rs * 32'h0020_0000) + (rt * 32'h0001_0000) + imm;
    return v;
  endfunction

  task automatic push_const(input int rt, input logic [31:0] v);
    int hi, lo;
    hi = int'(v / 65536);
    lo = int'(v % 65536);
    if (hi != 0) begin
      exp_q.push_back(mk(15, 0, rt, hi));
      exp_q.push_back(mk(13, rt, rt, lo));
    end else begin
      exp_q.push_back(mk(13, 0, rt, lo));
    end
  endtask

  task automatic model(input logic [1:0] op, input logic [4:0] r, input logic [31:0] a,
                       input logic [31:0] d);
    exp_q.delete();
    case (op)
      2'd0: push_const(int'(r), d);
      2'd1: begin push_const(26, a); exp_q.push_back(mk(35, 26, int'(r), 0)); end
      2'd2: begin push_const(26, a); push_const(27, d); exp_q.push_back(mk(43, 26, 27, 0)); end
      default: begin push_const(26, a); exp_q.push_back(mk(0, 26, 0, 8)); exp_q.push_back(32'h0); end
    endcase
  endtask

  task automatic issue(input logic [1:0] op, input logic [4:0] r, input logic [31:0] a,
                       input logic [31:0] d);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_reg = r; cmd_addr = a; cmd_data = d; inst_ready = 1'b0;
    #1;
    chk("cmd_ready_idle", cmd_ready, 1);
    chk("busy_idle", busy, 0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // mode 0: ready held high, 1: ready toggles 1010..., 2: random ready
  task automatic consume(input logic [1:0] op, input int mode);
    int i, cyc, len;
    logic [5:0] last_opc;
    i = 0; cyc = 0; len = exp_q.size();
    case (op)
      2'd0: last_opc = 6'h0D;
      2'd1: last_opc = 6'h23;
      2'd2: last_opc = 6'h2B;
      default: last_opc = 6'h00;
    endcase
    while (i < len && cyc < 64) begin
      @(negedge clk);
      inst_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      #1;
      chk("inst_valid", inst_valid, 1);
      chk("inst_word", inst, exp_q[i]);
      chk("cmd_ready_busy", cmd_ready, 0);
      if (inst_ready) begin
        chk("done_on_accept", done, (i == len - 1));
        if (i == len - 1) chk("decode_last_opcode", inst[31:26], last_opc);
        i++;
      end else begin
        chk("done_stalled", done, 0);
      end
      cyc++;
    end
    if (i < len) chk("stream_timeout", i, len);
    @(negedge clk);
    inst_ready = 1'b0;
    #1;
    chk("idle_inst_valid", inst_valid, 0);
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_inst_valid"}, inst_valid, 0);
    chk({tag, "_inst"}, inst, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [4:0]  r;
    logic [31:0] a, d;

    set_vec(0, 2'd0, 5'd5, 32'h0, 32'h12345678, 2, 32'h3C051234, 32'h34A55678, 0, 0, 0);
    set_vec(1, 2'd0, 5'd3, 32'h0, 32'h0000BEEF, 1, 32'h3403BEEF, 0, 0, 0, 0);
    set_vec(2, 2'd2, 5'd0, 32'hA0000010, 32'hDEADBEEF, 5,
            32'h3C1AA000, 32'h375A0010, 32'h3C1BDEAD, 32'h377BBEEF, 32'hAF5B0000);
    set_vec(3, 2'd1, 5'd9, 32'h00000040, 32'h0, 2, 32'h341A0040, 32'h8F490000, 0, 0, 0);
    set_vec(4, 2'd3, 5'd0, 32'h80001000, 32'h0, 4,
            32'h3C1A8000, 32'h375A1000, 32'h03400008, 32'h00000000, 0);
    set_vec(5, 2'd0, 5'd0, 32'h0, 32'h00000000, 1, 32'h34000000, 0, 0, 0, 0);
    set_vec(6, 2'd2, 5'd0, 32'h00001234, 32'h00000005, 3,
            32'h341A1234, 32'h341B0005, 32'hAF5B0000, 0, 0);
    set_vec(7, 2'd3, 5'd0, 32'h00000100, 32'h0, 3, 32'h341A0100, 32'h03400008, 32'h0, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++) begin
      exp_q.delete();
      for (int j = 0; j < vecs[k].len; j++) exp_q.push_back(vecs[k].w[j]);
      issue(vecs[k].op, vecs[k].r, vecs[k].addr, vecs[k].data);
      consume(vecs[k].op, (vecs[k].op == 2'd1) ? 1 : 0);
    end

    // abort after the first JUMP word has been consumed
    model(2'd3, 5'd0, 32'h80001000, 32'h0);
    issue(2'd3, 5'd0, 32'h80001000, 32'h0);
    @(negedge clk); inst_ready = 1'b1; #1;
    chk("abort_word0", inst, exp_q[0]);
    chk("abort_word0_done", done, 0);
    @(negedge clk); inst_ready = 1'b0; abort = 1'b1; #1;
    chk("abort_cycle_done", done, 0);
    chk("abort_cycle_word1", inst, exp_q[1]);
    @(negedge clk); abort = 1'b0; #1;
    chk("post_abort_inst_valid", inst_valid, 0);
    chk("post_abort_cmd_ready", cmd_ready, 1);
    chk("post_abort_busy", busy, 0);
    chk("post_abort_done", done, 0);

    // abort together with acceptance of the only word: no done pulse
    issue(2'd0, 5'd3, 32'h0, 32'h0000BEEF);
    @(negedge clk); inst_ready = 1'b1; abort = 1'b1; #1;
    chk("abort_last_done", done, 0);
    @(negedge clk); inst_ready = 1'b0; abort = 1'b0; #1;
    chk("abort_last_inst_valid", inst_valid, 0);
    chk("abort_last_busy", busy, 0);

    // asynchronous reset in the middle of a WR_MEM sequence
    issue(2'd2, 5'd0, 32'hA0000010, 32'hDEADBEEF);
    repeat (2) begin @(negedge clk); inst_ready = 1'b1; end
    @(negedge clk); inst_ready = 1'b0; rst_n = 1'b0; #1;
    check_reset_outputs("midseq_reset");
    @(negedge clk); rst_n = 1'b1;
    model(2'd0, 5'd5, 32'h0, 32'h12345678);
    issue(2'd0, 5'd5, 32'h0, 32'h12345678);
    consume(2'd0, 0);

    for (int n = 0; n < 30; n++) begin
      op = 2'($urandom_range(0, 3));
      r  = 5'($urandom);
      a  = $urandom;
      d  = $urandom;
      if ($urandom_range(0, 2) == 0) a[31:16] = 16'h0;
      if ($urandom_range(0, 2) == 0) d[31:16] = 16'h0;
      model(op, r, a, d);
      issue(op, r, a, d);
      consume(op, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
